// File: rtl/exec_ctrl_pkg.sv
// Shared constants and types for the execute-stage controller.
package exec_ctrl_pkg;

  // Major opcodes recognised by the controller
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Branch condition encodings
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Trap causes
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'd0;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DISPATCH,
    ST_WAIT_ALU,
    ST_COMMIT
  } state_t;

  // True for opcodes whose result comes from the external ALU
  function automatic logic is_alu_op(input logic [6:0] op);
    logic r;
    case (op)
      OP_REG, OP_IMM, OP_LOAD, OP_AUIPC, OP_LUI, OP_STORE: r = 1'b1;
      default:                                             r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/exec_ctrl_branch_cmp.sv
// Branch condition evaluator: decides taken / illegal from func3 and operands.
module branch_cmp
  import exec_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            taken,
  output logic            illegal
);

  // Pure compare; encodings 010/011 have no meaning and are flagged illegal
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (func3)
      F3_BEQ:  taken = (op_a == op_b);
      F3_BNE:  taken = (op_a != op_b);
      F3_BLT:  taken = ($signed(op_a) <  $signed(op_b));
      F3_BGE:  taken = ($signed(op_a) >= $signed(op_b));
      F3_BLTU: taken = (op_a <  op_b);
      F3_BGEU: taken = (op_a >= op_b);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/exec_ctrl.sv
// Execute-stage controller: accepts one decoded instruction at a time,
// resolves branches/jumps locally, hands ALU-class work to an external ALU
// and produces single-cycle commit pulses for the register file and PC.
module exec_ctrl
  import exec_ctrl_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int IBUS_W      = 37,
  parameter int ALU_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [6:0]        opcode,
  input  logic [2:0]        func3,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   rs1_value,
  input  logic [XLEN-1:0]   rs2_value,
  input  logic [XLEN-1:0]   imm,
  input  logic [IBUS_W-1:0] instr_bus,
  input  logic              rd_valid,
  output logic              alu_req,
  output logic [IBUS_W-1:0] alu_instr_bus,
  input  logic              alu_done,
  input  logic [XLEN-1:0]   alu_result,
  output logic              rd_write,
  output logic [XLEN-1:0]   rd_data,
  output logic              pc_update,
  output logic              pc_j_valid,
  output logic [XLEN-1:0]   next_pc,
  output logic              trap,
  output logic [1:0]        trap_cause,
  output logic [XLEN-1:0]   display_out,
  output logic              busy
);

  state_t state, state_next;

  logic [6:0]        opcode_q;
  logic [2:0]        func3_q;
  logic [XLEN-1:0]   pc_q, rs1_q, rs2_q, imm_q;
  logic [IBUS_W-1:0] ibus_q;
  logic              rd_valid_q;
  logic [7:0]        wait_cnt;

  logic [XLEN-1:0]   pc_plus4, rel_target, jalr_sum, jalr_target, jump_target;
  logic              br_taken, br_illegal;

  logic              cnt_clear, cnt_inc;
  logic              c_rd_write, c_pc_update, c_pc_j_valid, c_trap;
  logic [XLEN-1:0]   c_rd_data, c_next_pc;
  logic [1:0]        c_cause;

  // Address arithmetic wraps modulo 2^XLEN; JALR clears bit 0 of its sum
  assign pc_plus4    = pc_q + XLEN'(4);
  assign rel_target  = pc_q + imm_q;
  assign jalr_sum    = rs1_q + imm_q;
  assign jalr_target = jalr_sum & ~XLEN'(1);
  assign jump_target = (opcode_q == OP_JAL) ? rel_target : jalr_target;

  branch_cmp #(.XLEN(XLEN)) u_branch_cmp (
    .func3   (func3_q),
    .op_a    (rs1_q),
    .op_b    (rs2_q),
    .taken   (br_taken),
    .illegal (br_illegal)
  );

  assign issue_ready   = (state == ST_IDLE);
  assign busy          = (state != ST_IDLE);
  assign alu_req       = ((state == ST_DISPATCH) && is_alu_op(opcode_q)) || (state == ST_WAIT_ALU);
  assign alu_instr_bus = ibus_q;

  // State register; reset drops straight to IDLE even mid-wait
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next state plus the commit results that are registered on entry to COMMIT
  always_comb begin
    state_next   = state;
    cnt_clear    = 1'b0;
    cnt_inc      = 1'b0;
    c_rd_write   = 1'b0;
    c_rd_data    = '0;
    c_pc_update  = 1'b0;
    c_pc_j_valid = 1'b0;
    c_next_pc    = '0;
    c_trap       = 1'b0;
    c_cause      = CAUSE_ILLEGAL;
    case (state)
      ST_IDLE: begin
        if (issue_valid) state_next = ST_DISPATCH;
      end
      ST_DISPATCH: begin
        if (is_alu_op(opcode_q)) begin
          state_next = ST_WAIT_ALU;
          cnt_clear  = 1'b1;
        end else begin
          state_next = ST_COMMIT;
          case (opcode_q)
            OP_BRANCH: begin
              if (br_illegal) begin
                c_trap  = 1'b1;
                c_cause = CAUSE_ILLEGAL;
              end else if (br_taken && (rel_target[1:0] != 2'b00)) begin
                c_trap  = 1'b1;
                c_cause = CAUSE_MISALIGN;
              end else begin
                c_pc_update  = 1'b1;
                c_pc_j_valid = br_taken;
                c_next_pc    = br_taken ? rel_target : pc_plus4;
              end
            end
            OP_JAL, OP_JALR: begin
              if (jump_target[1:0] != 2'b00) begin
                c_trap  = 1'b1;
                c_cause = CAUSE_MISALIGN;
              end else begin
                c_pc_update  = 1'b1;
                c_pc_j_valid = 1'b1;
                c_next_pc    = jump_target;
                c_rd_write   = rd_valid_q;
                c_rd_data    = pc_plus4;
              end
            end
            default: begin
              c_trap  = 1'b1;
              c_cause = CAUSE_ILLEGAL;
            end
          endcase
        end
      end
      ST_WAIT_ALU: begin
        if (alu_done) begin
          state_next  = ST_COMMIT;
          c_rd_write  = rd_valid_q && (opcode_q != OP_STORE);
          c_rd_data   = alu_result;
          c_pc_update = 1'b1;
          c_next_pc   = pc_plus4;
        end else if (wait_cnt == 8'(ALU_TIMEOUT - 1)) begin
          state_next = ST_COMMIT;
          c_trap     = 1'b1;
          c_cause    = CAUSE_TIMEOUT;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_COMMIT: begin
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Operand capture on an accepted handshake; ignored at all other times
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q   <= '0;
      func3_q    <= '0;
      pc_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      imm_q      <= '0;
      ibus_q     <= '0;
      rd_valid_q <= 1'b0;
    end else if ((state == ST_IDLE) && issue_valid) begin
      opcode_q   <= opcode;
      func3_q    <= func3;
      pc_q       <= pc;
      rs1_q      <= rs1_value;
      rs2_q      <= rs2_value;
      imm_q      <= imm;
      ibus_q     <= instr_bus;
      rd_valid_q <= rd_valid;
    end
  end

  // Counts WAIT_ALU cycles that ended without alu_done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         wait_cnt <= '0;
    else if (cnt_clear) wait_cnt <= '0;
    else if (cnt_inc)   wait_cnt <= wait_cnt + 8'd1;
  end

  // Commit outputs: pulses last one cycle, data fields hold until next update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_write    <= 1'b0;
      rd_data     <= '0;
      display_out <= '0;
      pc_update   <= 1'b0;
      pc_j_valid  <= 1'b0;
      next_pc     <= '0;
      trap        <= 1'b0;
      trap_cause  <= '0;
    end else begin
      rd_write  <= c_rd_write;
      pc_update <= c_pc_update;
      trap      <= c_trap;
      if (c_rd_write) begin
        rd_data     <= c_rd_data;
        display_out <= c_rd_data;
      end
      if (c_pc_update) begin
        next_pc    <= c_next_pc;
        pc_j_valid <= c_pc_j_valid;
      end
      if (c_trap) trap_cause <= c_cause;
    end
  end

endmodule

// File: tb/tb_exec_ctrl.sv
// Self-checking bench for exec_ctrl: vector table driven through a scoreboard,
// plus reset and mid-wait reset sequences.
module tb_exec_ctrl;
  import exec_ctrl_pkg::*;

  localparam int XLEN        = 32;
  localparam int IBUS_W      = 37;
  localparam int ALU_TIMEOUT = 15;
  localparam int NO_DONE     = 255;
  localparam int NVEC        = 19;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              issue_valid = 1'b0;
  logic              issue_ready;
  logic [6:0]        opcode = '0;
  logic [2:0]        func3 = '0;
  logic [XLEN-1:0]   pc = '0, rs1_value = '0, rs2_value = '0, imm = '0;
  logic [IBUS_W-1:0] instr_bus = '0;
  logic              rd_valid = 1'b0;
  logic              alu_req;
  logic [IBUS_W-1:0] alu_instr_bus;
  logic              alu_done = 1'b0;
  logic [XLEN-1:0]   alu_result = '0;
  logic              rd_write;
  logic [XLEN-1:0]   rd_data;
  logic              pc_update, pc_j_valid;
  logic [XLEN-1:0]   next_pc;
  logic              trap;
  logic [1:0]        trap_cause;
  logic [XLEN-1:0]   display_out;
  logic              busy;

  typedef struct {
    int          id;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [31:0] pc, rs1, rs2, imm;
    logic        rd_valid;
    int          alu_n;
    logic [31:0] alu_res;
    logic        e_rd_write;
    logic [31:0] e_rd_data;
    logic        e_pc_update;
    logic        e_j;
    logic [31:0] e_next_pc;
    logic        e_trap;
    logic [1:0]  e_cause;
    int          e_lat;
    int          t_xfer;
  } vec_t;

  vec_t vecs [NVEC];
  vec_t sb[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] last_rd   = '0;
  logic [31:0] last_npc  = '0;
  logic [1:0]  last_caus = '0;

  exec_ctrl #(.XLEN(XLEN), .IBUS_W(IBUS_W), .ALU_TIMEOUT(ALU_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .opcode(opcode), .func3(func3),
    .pc(pc), .rs1_value(rs1_value), .rs2_value(rs2_value), .imm(imm),
    .instr_bus(instr_bus), .rd_valid(rd_valid),
    .alu_req(alu_req), .alu_instr_bus(alu_instr_bus),
    .alu_done(alu_done), .alu_result(alu_result),
    .rd_write(rd_write), .rd_data(rd_data),
    .pc_update(pc_update), .pc_j_valid(pc_j_valid), .next_pc(next_pc),
    .trap(trap), .trap_cause(trap_cause),
    .display_out(display_out), .busy(busy)
  );

  // 10 ns clock and a free-running edge counter for latency measurement
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case something hangs despite the bounded waits
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3,
                              input logic [31:0] vpc, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] im, input logic rdv, input int n, input logic [31:0] res,
                              input logic erw, input logic [31:0] erd, input logic epu, input logic ej,
                              input logic [31:0] enpc, input logic etr, input logic [1:0] ec, input int lat);
    vec_t v;
    v.id = 0; v.opcode = op; v.func3 = f3; v.pc = vpc; v.rs1 = a; v.rs2 = b; v.imm = im;
    v.rd_valid = rdv; v.alu_n = n; v.alu_res = res;
    v.e_rd_write = erw; v.e_rd_data = erd; v.e_pc_update = epu; v.e_j = ej;
    v.e_next_pc = enpc; v.e_trap = etr; v.e_cause = ec; v.e_lat = lat; v.t_xfer = 0;
    return v;
  endfunction

  // Scoreboard consumer: every commit shows either pc_update or trap
  always @(negedge clk) begin : monitor
    vec_t e;
    if (rst_n && (pc_update || trap)) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_commit", 64'(1), 64'(0));
      end else begin
        e = sb.pop_front();
        checkOutput($sformatf("v%0d rd_write", e.id), 64'(rd_write), 64'(e.e_rd_write));
        checkOutput($sformatf("v%0d pc_update", e.id), 64'(pc_update), 64'(e.e_pc_update));
        checkOutput($sformatf("v%0d trap", e.id), 64'(trap), 64'(e.e_trap));
        if (e.e_rd_write) last_rd = e.e_rd_data;
        checkOutput($sformatf("v%0d rd_data", e.id), 64'(rd_data), 64'(last_rd));
        checkOutput($sformatf("v%0d display_out", e.id), 64'(display_out), 64'(last_rd));
        if (e.e_pc_update) begin
          last_npc = e.e_next_pc;
          checkOutput($sformatf("v%0d pc_j_valid", e.id), 64'(pc_j_valid), 64'(e.e_j));
        end
        checkOutput($sformatf("v%0d next_pc", e.id), 64'(next_pc), 64'(last_npc));
        if (e.e_trap) last_caus = e.e_cause;
        checkOutput($sformatf("v%0d trap_cause", e.id), 64'(trap_cause), 64'(last_caus));
        checkOutput($sformatf("v%0d alu_req_at_commit", e.id), 64'(alu_req), 64'(0));
        checkOutput($sformatf("v%0d latency", e.id), 64'(cyc - e.t_xfer + 1), 64'(e.e_lat));
      end
    end
  end

  // Drives one vector from a negedge, answers as the ALU, waits for IDLE again
  task automatic applyStimulus(input int idx);
    vec_t v;
    logic [IBUS_W-1:0] ibus_val;
    logic is_alu;
    int k;
    v = vecs[idx];
    v.id = idx;
    is_alu = is_alu_op(v.opcode);
    ibus_val = {5'(idx), ~v.pc};
    opcode = v.opcode; func3 = v.func3; pc = v.pc;
    rs1_value = v.rs1; rs2_value = v.rs2; imm = v.imm;
    rd_valid = v.rd_valid; instr_bus = ibus_val;
    issue_valid = 1'b1;
    @(posedge clk);
    #1;
    v.t_xfer = cyc;
    sb.push_back(v);
    issue_valid = 1'b0;
    opcode = 7'h7F; func3 = 3'($urandom); pc = $urandom; rs1_value = $urandom;
    rs2_value = $urandom; imm = $urandom; rd_valid = ~v.rd_valid; instr_bus = '1;
    @(negedge clk);
    checkOutput($sformatf("v%0d alu_req_dispatch", idx), 64'(alu_req), 64'(is_alu));
    if (is_alu) checkOutput($sformatf("v%0d alu_instr_bus", idx), 64'(alu_instr_bus), 64'(ibus_val));
    if (is_alu && v.alu_n < NO_DONE) begin
      repeat (1 + v.alu_n) @(posedge clk);
      #1;
      alu_done = 1'b1;
      alu_result = v.alu_res;
      @(posedge clk);
      #1;
      alu_done = 1'b0;
      alu_result = $urandom;
    end
    k = 0;
    while (!issue_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!issue_ready) checkOutput($sformatf("v%0d ready_timeout", idx), 64'(issue_ready), 64'(1));
  endtask

  initial begin
    // id, opcode, func3, pc, rs1, rs2, imm, rd_valid, alu_n, alu_res,
    // exp: rd_write, rd_data, pc_update, j, next_pc, trap, cause, latency
    vecs[0]  = mk(OP_BRANCH, F3_BEQ,  32'h100, 32'h5, 32'h5, 32'h20, 0, 0, 0,
                  0, 0, 1, 1, 32'h120, 0, 0, 2);
    vecs[1]  = mk(OP_BRANCH, F3_BLTU, 32'h200, 32'hFFFFFFFF, 32'h1, 32'h10, 0, 0, 0,
                  0, 0, 1, 0, 32'h204, 0, 0, 2);
    vecs[2]  = mk(OP_BRANCH, F3_BLT,  32'h200, 32'hFFFFFFFF, 32'h1, 32'h10, 0, 0, 0,
                  0, 0, 1, 1, 32'h210, 0, 0, 2);
    vecs[3]  = mk(OP_IMM, 3'b000, 32'h300, 32'h7, 32'h0, 32'h23, 1, 3, 32'h2A,
                  1, 32'h2A, 1, 0, 32'h304, 0, 0, 6);
    vecs[4]  = mk(OP_JALR, 3'b000, 32'h40, 32'h201, 32'h0, 32'h1, 1, 0, 0,
                  0, 0, 0, 0, 0, 1, CAUSE_MISALIGN, 2);
    vecs[5]  = mk(OP_JALR, 3'b000, 32'h40, 32'h201, 32'h0, 32'h3, 1, 0, 0,
                  1, 32'h44, 1, 1, 32'h204, 0, 0, 2);
    vecs[6]  = mk(OP_JAL, 3'b000, 32'h1000, 32'h0, 32'h0, 32'hFFFFFFF0, 1, 0, 0,
                  1, 32'h1004, 1, 1, 32'hFF0, 0, 0, 2);
    vecs[7]  = mk(OP_BRANCH, 3'b010, 32'h20, 32'h1, 32'h1, 32'h8, 0, 0, 0,
                  0, 0, 0, 0, 0, 1, CAUSE_ILLEGAL, 2);
    vecs[8]  = mk(7'h7F, 3'b000, 32'h24, 32'h0, 32'h0, 32'h0, 1, 0, 0,
                  0, 0, 0, 0, 0, 1, CAUSE_ILLEGAL, 2);
    vecs[9]  = mk(OP_STORE, 3'b010, 32'h28, 32'h0, 32'h0, 32'h0, 1, 0, 32'h55,
                  0, 0, 1, 0, 32'h2C, 0, 0, 3);
    vecs[10] = mk(OP_BRANCH, F3_BNE, 32'hFFFFFFFC, 32'h3, 32'h3, 32'h40, 0, 0, 0,
                  0, 0, 1, 0, 32'h0, 0, 0, 2);
    vecs[11] = mk(OP_BRANCH, F3_BGE, 32'h500, 32'h80000000, 32'h0, 32'h8, 0, 0, 0,
                  0, 0, 1, 0, 32'h504, 0, 0, 2);
    vecs[12] = mk(OP_BRANCH, F3_BGEU, 32'h500, 32'h80000000, 32'h0, 32'h8, 0, 0, 0,
                  0, 0, 1, 1, 32'h508, 0, 0, 2);
    vecs[13] = mk(OP_BRANCH, F3_BEQ, 32'h600, 32'h0, 32'h0, 32'h6, 0, 0, 0,
                  0, 0, 0, 0, 0, 1, CAUSE_MISALIGN, 2);
    vecs[14] = mk(OP_BRANCH, F3_BEQ, 32'h600, 32'h1, 32'h0, 32'h6, 0, 0, 0,
                  0, 0, 1, 0, 32'h604, 0, 0, 2);
    vecs[15] = mk(OP_LUI, 3'b000, 32'h700, 32'h0, 32'h0, 32'h1000, 0, 1, 32'h1234,
                  0, 0, 1, 0, 32'h704, 0, 0, 4);
    vecs[16] = mk(OP_REG, 3'b000, 32'h720, 32'h1, 32'h2, 32'h0, 1, NO_DONE, 0,
                  0, 0, 0, 0, 0, 1, CAUSE_TIMEOUT, ALU_TIMEOUT + 2);
    vecs[17] = mk(OP_LOAD, 3'b010, 32'h800, 32'h10, 32'h0, 32'h4, 1, 5, 32'hDEADBEEF,
                  1, 32'hDEADBEEF, 1, 0, 32'h804, 0, 0, 8);
    vecs[18] = mk(OP_AUIPC, 3'b000, 32'h10, 32'h0, 32'h0, 32'h0, 1, 0, 32'h77,
                  1, 32'h77, 1, 0, 32'h14, 0, 0, 3);

    // Power-on reset: outputs idle and zero
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset issue_ready", 64'(issue_ready), 64'(1));
    checkOutput("reset busy", 64'(busy), 64'(0));
    checkOutput("reset alu_req", 64'(alu_req), 64'(0));
    checkOutput("reset rd_write", 64'(rd_write), 64'(0));
    checkOutput("reset pc_update", 64'(pc_update), 64'(0));
    checkOutput("reset trap", 64'(trap), 64'(0));
    checkOutput("reset next_pc", 64'(next_pc), 64'(0));
    checkOutput("reset display_out", 64'(display_out), 64'(0));
    rst_n = 1'b1;

    // Table-driven vectors; the first is offered right as reset releases
    for (int i = 0; i < NVEC - 1; i++) applyStimulus(i);

    // ALU op left hanging, then an asynchronous reset in the middle of the wait
    opcode = OP_REG; func3 = 3'b000; pc = 32'h900; rs1_value = 32'h1; rs2_value = 32'h2;
    imm = 32'h0; rd_valid = 1'b1; instr_bus = '0;
    issue_valid = 1'b1;
    @(posedge clk);
    #1 issue_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("midwait alu_req_before", 64'(alu_req), 64'(1));
    checkOutput("midwait busy_before", 64'(busy), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midwait alu_req", 64'(alu_req), 64'(0));
    checkOutput("midwait issue_ready", 64'(issue_ready), 64'(1));
    checkOutput("midwait busy", 64'(busy), 64'(0));
    checkOutput("midwait rd_data", 64'(rd_data), 64'(0));
    checkOutput("midwait display_out", 64'(display_out), 64'(0));
    checkOutput("midwait next_pc", 64'(next_pc), 64'(0));
    last_rd = '0; last_npc = '0; last_caus = '0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(NVEC - 1);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exec_ctrl.md
EXEC_CTRL -- requirements
Module: exec_ctrl

Interface
REQ-001 Parameter XLEN, default 32, datapath width of operands, PC, results.
REQ-002 Parameter IBUS_W, default 37, width of decoded instruction bus passed to the ALU.
REQ-003 Parameter ALU_TIMEOUT, default 15, maximum WAIT_ALU cycles before abort (range 1..255).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 issue_valid / issue_ready  in / out  1  instruction handshake; transfer when both high at an edge.
REQ-007 opcode, func3  in  7, 3  decoded fields, sampled at transfer.
REQ-008 pc, rs1_value, rs2_value, imm  in  XLEN  operands, sampled at transfer.
REQ-009 instr_bus  in  IBUS_W, rd_valid  in  1  decoded bus and destination-valid flag, sampled at transfer.
REQ-010 alu_req  out  1, alu_instr_bus  out  IBUS_W  ALU request and its instruction bus.
REQ-011 alu_done  in  1, alu_result  in  XLEN  ALU completion and its result.
REQ-012 rd_write  out  1, rd_data  out  XLEN  register-file write pulse and data.
REQ-013 pc_update  out  1, pc_j_valid  out  1, next_pc  out  XLEN  PC update pulse, taken flag, new PC.
REQ-014 trap  out  1, trap_cause  out  2  fault pulse; cause 0 illegal, 1 misaligned target, 2 ALU timeout.
REQ-015 display_out  out  XLEN  last value written to the register file; busy  out  1  high whenever not IDLE.

Function
REQ-016 FSM states IDLE, DISPATCH, WAIT_ALU, COMMIT; issue_ready SHALL equal (state==IDLE).
REQ-017 IDLE->DISPATCH on transfer; operands latched into internal registers; inputs otherwise ignored outside IDLE.
REQ-018 ALU class (0110011, 0010011, 0000011, 0010111, 0110111, 0100011): DISPATCH->WAIT_ALU; alu_req high from DISPATCH until the cycle alu_done is sampled high in WAIT_ALU, inclusive.
REQ-019 WAIT_ALU->COMMIT on alu_done; alu_result captured; rd_write at COMMIT iff rd_valid and opcode != 0100011 (stores never write).
REQ-020 WAIT_ALU cycle counter; reaching ALU_TIMEOUT cycles without alu_done -> COMMIT with trap, cause 2, alu_req dropped, no rd_write, no pc_update.
REQ-021 Branch 1100011: no ALU; DISPATCH->COMMIT; func3 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge; 010/011 -> trap cause 0.
REQ-022 JAL 1101111 target pc+imm; JALR 1100111 target (rs1_value+imm) with bit0 cleared; both: rd_data=pc+4, rd_write iff rd_valid, no ALU.
REQ-023 Any other opcode -> trap cause 0, no rd_write, no pc_update.
REQ-024 Taken target with bits[1:0] != 0 -> trap cause 1; suppresses rd_write and pc_update.
REQ-025 COMMIT (exactly one cycle) SHALL pulse pc_update with next_pc = target if taken, else pc+4, and pc_j_valid = taken; COMMIT->IDLE.
REQ-026 All additions modulo 2^XLEN; pc+4 wraps silently.
REQ-027 rd_write, pc_update, trap single-cycle pulses; rd_data, next_pc, trap_cause hold last value otherwise.
REQ-028 display_out updated with rd_data in the same cycle rd_write pulses.
REQ-029 Latency transfer-to-commit: 2 cycles non-ALU; 3+N cycles ALU where N = WAIT_ALU cycles before alu_done.

Reset
REQ-030 rst_n low SHALL immediately force IDLE and zero every output and counter, including mid-WAIT_ALU (alu_req drops asynchronously).
REQ-031 First transfer accepted at the first rising edge after rst_n deasserts.

Structure
REQ-032 Package exec_ctrl_pkg SHALL hold opcode constants, branch func3 constants, trap-cause constants, state enum.
REQ-033 One sub-module, branch_cmp: combinational, func3 + two XLEN operands -> taken, illegal.

Verification
REQ-034 BEQ rs1=5, rs2=5, pc=0x100, imm=0x20 -> COMMIT pulse, next_pc=0x120, pc_j_valid=1, no rd_write.
REQ-035 BLTU rs1=0xFFFFFFFF, rs2=1 -> not taken, next_pc=pc+4; BLT same operands -> taken.
REQ-036 ADDI, rd_valid=1, alu_done after 3 WAIT_ALU cycles, alu_result=0x2A -> rd_write, rd_data=0x2A, display_out=0x2A, commit 6 cycles after transfer.
REQ-037 JALR rs1=0x201, imm=0x1, pc=0x40 -> next_pc=0x202 misaligned: trap cause 1, no rd_write, no pc_update; imm=0x3 -> next_pc=0x204, rd_data=0x44.
REQ-038 ALU op with alu_done held low -> trap cause 2 after ALU_TIMEOUT cycles; rst_n pulse mid-wait -> IDLE, alu_req=0, issue_ready=1.
